bus_ir_transmitter: RTL and testbench
=====================================

// Module: bus_ir_transmitter
// PURPOSE
//  Memory-mapped IR packet transmitter on the shared 8-bit processor bus. It sits beside the data RAM.
//  The processor writes a trolley command byte. The block serialises it as carrier-modulated bursts on IR_LED.
//  Bus reads return the command and status registers through the same registered tristate scheme as the RAM.
// PARAMETERS
//  BASE_ADDR      8'h90  CMD register at BASE_ADDR, STATUS register at BASE_ADDR+1
//  CARRIER_HALF   1389   CLK cycles per carrier half-period (36 kHz at 100 MHz)
//  START_BURST    88     carrier cycles in the start burst
//  SEL_BURST      22     carrier cycles in the car-select burst
//  ONE_BURST      44     carrier cycles for a command bit = 1
//  ZERO_BURST     22     carrier cycles for a command bit = 0
//  GAP_LEN        40     carrier cycles of silence after every burst
//  REPEAT_PERIOD  24'd10_000_000  CLK cycles between auto-repeats (optional feature only)
// PORTS
//  CLK       in     1  system clock
//  RESET_N   in     1  asynchronous active-low reset
//  BUS_DATA  inout  8  shared data bus; driven only while a read of this block is pending
//  BUS_ADDR  in     8  bus address
//  BUS_WE    in     1  bus write enable, 1 = processor write
//  IR_LED    out    1  modulated IR output
//  BUSY      out    1  1 while a packet is in flight
// BEHAVIOUR
//  - Reset (async, RESET_N=0): IR_LED=0, BUSY=0, CMD=0, pending flag=0, bus drive off (BUS_DATA=Z), FSM=IDLE, all counters=0.
//  - Write: at posedge CLK, if BUS_WE=1 and BUS_ADDR==BASE_ADDR, then CMD<=BUS_DATA and pending<=1.
//    Writes to BASE_ADDR+1 are ignored.
//  - Read: at posedge CLK, if BUS_WE=0 and the address hits either register, the drive enable and output data register are set.
//    Data = CMD, or {6'b0,pending,BUSY}. BUS_DATA is valid one cycle after the address (same latency as RAM).
//    On any other address, or when BUS_WE=1, drive is released next cycle.
//  - Carrier: a free-running counter toggles carrier every CARRIER_HALF CLKs. A burst counts carrier rising edges.
//  - FSM states: IDLE -> START -> GAP -> SEL -> GAP -> BIT(i=3..0) -> GAP after each bit -> IDLE.
//    - IDLE: if pending=1, latch CMD into shift reg, clear pending, BUSY<=1, go to START.
//    - SEL burst is always SEL_BURST. BIT length is ONE_BURST or ZERO_BURST from shift[3:0], MSB first.
//    - After the final GAP: BUSY<=0, return to IDLE. A new pending command starts on the next cycle.
//  - IR_LED = carrier & (state in START/SEL/BIT), registered. It is 0 in GAP and IDLE.
//  - Write during BUSY: the packet in flight is unaffected. The write updates CMD and sets pending, so one packet queues.
//    Further writes overwrite it (last write wins, no overflow flag).
//  - Simultaneous write and packet-start cycle: the FSM latches the old CMD. The new write sets pending again.
//  - Counter wrap: burst and gap counters clear on every state change and never wrap mid-state.
//  - Reset mid-packet: IR_LED drops immediately (async). The queued command is discarded.
// CONFIGURATION
//  IR_AUTO_REPEAT_EN defined: a REPEAT_PERIOD counter runs while IDLE.
//   On terminal count with pending=0, the last transmitted command is re-sent and the counter restarts.
//   Any write restarts the counter.
//  IR_AUTO_REPEAT_EN undefined: packets are sent only on writes. The repeat counter is not synthesised.
// TESTING (bench params: CARRIER_HALF=2, START_BURST=4, SEL_BURST=2, ONE_BURST=3, ZERO_BURST=1, GAP_LEN=2)
//  1 Assert RESET_N=0 during a burst -> IR_LED=0 and BUSY=0 in the same cycle. BUS_DATA=Z. A read of 0x91 after release returns 8'h00.
//  2 Write 0x90<=8'h0A, then idle -> bursts of 4,2,3,1,3,1 carrier cycles, each followed by 2 silent cycles. BUSY falls after the last gap.
//  3 Read 0x90 after the write of 8'h0A -> BUS_DATA=8'h0A exactly one CLK after the address. Z on the next cycle with another address.
//  4 Write 8'h05 then 8'h0F during BUSY -> status reads 8'h03. The next packet carries 0xF bits; 0x5 is never sent.
//  5 Write to 0x91 and read 0x92 -> no state change. BUS_DATA stays Z.
//  6 [IR_AUTO_REPEAT_EN, REPEAT_PERIOD=50] Send 8'h09, then no writes -> identical packet re-sent 50 CLKs after each return to IDLE.

Source files
------------

// File: rtl/bus_ir_transmitter.sv
// bus_ir_transmitter: memory-mapped IR packet transmitter on the 8-bit processor bus.
// CMD register at BASE_ADDR, STATUS ({6'b0, pending, busy}) at BASE_ADDR+1.
// A written command byte is sent as START, SEL and four bit bursts (bits 3..0, MSB
// first), each followed by a silent gap. Reads use the registered tristate scheme
// of the data RAM: data appears one clock after the address.
// Optional feature: define IR_AUTO_REPEAT_EN to re-send the last command every
// REPEAT_PERIOD clocks while idle.
module bus_ir_transmitter #(
    parameter logic [7:0] BASE_ADDR    = 8'h90,
    parameter int         CARRIER_HALF = 1389,
    parameter int         START_BURST  = 88,
    parameter int         SEL_BURST    = 22,
    parameter int         ONE_BURST    = 44,
    parameter int         ZERO_BURST   = 22,
    parameter int         GAP_LEN      = 40
`ifdef IR_AUTO_REPEAT_EN
    ,
    parameter logic [23:0] REPEAT_PERIOD = 24'd10_000_000
`endif
) (
    input  logic       CLK,
    input  logic       RESET_N,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       IR_LED,
    output logic       BUSY
);

    localparam int HALF_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(CARRIER_HALF - 1);
    localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_GAP, S_SEL, S_BIT} state_t;
    typedef enum logic [1:0] {P_START, P_SEL, P_BIT} phase_t;

    state_t             state_q, state_d;
    phase_t             from_q, from_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic               carrier_q, carrier_d;
    logic [3:0]         shift_q, shift_d;
    logic [1:0]         bit_q, bit_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;
    logic [7:0]         cmd_q;
    logic               pending_q;
    logic               drive_q;
    logic [7:0]         rdata_q;

    logic               wr_cmd;
    logic               rd_hit;
    logic               rise;
    logic               start_pkt;
    logic               take_pending;
    logic               repeat_fire;
    logic [15:0]        len_last;

    assign wr_cmd = BUS_WE && (BUS_ADDR == BASE_ADDR);
    assign rd_hit = !BUS_WE && ((BUS_ADDR == BASE_ADDR) || (BUS_ADDR == STAT_ADDR));
    // A carrier rising edge happens at the next clock when the low half expires.
    assign rise   = (half_q == HALF_MAX) && !carrier_q;

    assign BUS_DATA = drive_q ? rdata_q : 8'hzz;
    assign IR_LED   = led_q;
    assign BUSY     = busy_q;

`ifdef IR_AUTO_REPEAT_EN
    logic [23:0] rep_q;
    logic        sent_q;

    assign repeat_fire = (state_q == S_IDLE) && !pending_q && sent_q && !wr_cmd &&
                         (rep_q == REPEAT_PERIOD - 24'd1);

    // Repeat timer: runs only while idle, restarted by writes and by every packet.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_q  <= 24'd0;
            sent_q <= 1'b0;
        end else begin
            if (start_pkt)
                sent_q <= 1'b1;
            if (wr_cmd || (state_q != S_IDLE) || repeat_fire)
                rep_q <= 24'd0;
            else
                rep_q <= rep_q + 24'd1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Length (minus one) of the current burst or gap, in carrier cycles.
    always_comb begin
        len_last = 16'(GAP_LEN - 1);
        case (state_q)
            S_START: len_last = 16'(START_BURST - 1);
            S_SEL:   len_last = 16'(SEL_BURST - 1);
            S_BIT:   len_last = shift_q[bit_q] ? 16'(ONE_BURST - 1) : 16'(ZERO_BURST - 1);
            default: len_last = 16'(GAP_LEN - 1);
        endcase
    end

    // Packet sequencer next state: bursts and gaps end on the carrier rising edge
    // that completes their count, so every state after START begins phase-aligned.
    always_comb begin
        state_d      = state_q;
        from_d       = from_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        busy_d       = busy_q;
        start_pkt    = 1'b0;
        take_pending = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q || repeat_fire) begin
                    start_pkt = 1'b1;
                    if (pending_q) begin
                        take_pending = 1'b1;
                        shift_d      = cmd_q[3:0];
                    end
                    state_d = S_START;
                    cnt_d   = 16'd0;
                    bit_d   = 2'd3;
                    busy_d  = 1'b1;
                end
            end
            S_START, S_SEL, S_BIT: begin
                if (rise) begin
                    if (cnt_q == len_last) begin
                        state_d = S_GAP;
                        cnt_d   = 16'd0;
                        if (state_q == S_START)
                            from_d = P_START;
                        else if (state_q == S_SEL)
                            from_d = P_SEL;
                        else
                            from_d = P_BIT;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_GAP: begin
                if (rise) begin
                    if (cnt_q == len_last) begin
                        cnt_d = 16'd0;
                        case (from_q)
                            P_START: state_d = S_SEL;
                            P_SEL: begin
                                state_d = S_BIT;
                                bit_d   = 2'd3;
                            end
                            default: begin
                                if (bit_q == 2'd0) begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                end else begin
                                    state_d = S_BIT;
                                    bit_d   = bit_q - 2'd1;
                                end
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Carrier generator: free-running, but restarted high at packet start so the
    // START burst contains exactly START_BURST whole carrier cycles.
    always_comb begin
        half_d    = half_q + HALF_W'(1);
        carrier_d = carrier_q;
        if (half_q == HALF_MAX) begin
            half_d    = '0;
            carrier_d = ~carrier_q;
        end
        if (start_pkt) begin
            half_d    = '0;
            carrier_d = 1'b1;
        end
        led_d = carrier_d && ((state_d == S_START) || (state_d == S_SEL) || (state_d == S_BIT));
    end

    // Sequencer, carrier and LED registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            from_q    <= P_START;
            cnt_q     <= 16'd0;
            half_q    <= '0;
            carrier_q <= 1'b0;
            shift_q   <= 4'd0;
            bit_q     <= 2'd0;
            busy_q    <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            from_q    <= from_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            carrier_q <= carrier_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            busy_q    <= busy_d;
            led_q     <= led_d;
        end
    end

    // Command register and pending flag; a write wins over the packet-start clear.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_q     <= 8'd0;
            pending_q <= 1'b0;
        end else if (wr_cmd) begin
            cmd_q     <= BUS_DATA;
            pending_q <= 1'b1;
        end else if (take_pending) begin
            pending_q <= 1'b0;
        end
    end

    // Registered read port: drive the bus the cycle after a read hit, release otherwise.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            drive_q <= 1'b0;
            rdata_q <= 8'd0;
        end else if (rd_hit) begin
            drive_q <= 1'b1;
            rdata_q <= (BUS_ADDR == BASE_ADDR) ? cmd_q : {6'b0, pending_q, busy_q};
        end else begin
            drive_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_ir_transmitter.sv
// Directed bench for bus_ir_transmitter with shortened timing parameters.
module tb_bus_ir_transmitter;

    localparam logic [7:0] CMD_A  = 8'h90;
    localparam logic [7:0] STAT_A = 8'h91;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       tb_en;
    logic [7:0] tb_drv;
    wire  [7:0] BUS_DATA;
    wire        IR_LED;
    wire        BUSY;

    int n_cmp = 0;
    int n_err = 0;
    int cap_cycles, cap_high, cap_nb, cap_badgap;
    int cap_len[8];

    assign BUS_DATA = tb_en ? tb_drv : 8'hzz;

    always #5 CLK = ~CLK;

    bus_ir_transmitter #(
        .BASE_ADDR   (8'h90),
        .CARRIER_HALF(2),
        .START_BURST (4),
        .SEL_BURST   (2),
        .ONE_BURST   (3),
        .ZERO_BURST  (1),
        .GAP_LEN     (2)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .BUS_DATA(BUS_DATA),
        .BUS_ADDR(BUS_ADDR),
        .BUS_WE  (BUS_WE),
        .IR_LED  (IR_LED),
        .BUSY    (BUSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        BUS_ADDR = addr;
        BUS_WE   = 1'b1;
        tb_drv   = data;
        tb_en    = 1'b1;
        @(negedge CLK);
        BUS_WE   = 1'b0;
        tb_en    = 1'b0;
        BUS_ADDR = 8'h00;
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [7:0] d);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        tb_en    = 1'b0;
        @(negedge CLK);
        d        = BUS_DATA;
        BUS_ADDR = 8'h00;
    endtask

    // Drives zero onto the bus for a moment; any DUT drive shows up as a non-zero or unknown value.
    task automatic check_released(input string tag);
        @(negedge CLK);
        tb_drv = 8'h00;
        tb_en  = 1'b1;
        #1;
        check(tag, {24'd0, BUS_DATA}, 32'h0);
        tb_en  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (BUSY !== 1'b0 && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        check(tag, {31'd0, guard < 400}, 32'd1);
    endtask

    // Records one packet: pulses per burst, busy length, high cycles, gap lengths.
    task automatic capture_packet();
        int   guard;
        int   zrun;
        logic prev;
        cap_cycles = 0;
        cap_high   = 0;
        cap_nb     = 0;
        cap_badgap = 0;
        for (int i = 0; i < 8; i++) cap_len[i] = 0;
        guard = 0;
        while (BUSY !== 1'b1 && guard < 400) begin
            @(negedge CLK);
            guard++;
        end
        prev = 1'b0;
        zrun = 0;
        while (BUSY === 1'b1 && guard < 800) begin
            if (IR_LED === 1'b1) begin
                if (!prev) begin
                    if (cap_cycles == 0 || zrun >= 6) begin
                        if (cap_cycles != 0 && zrun != 10) cap_badgap++;
                        if (cap_nb < 8) cap_nb++;
                    end
                    if (cap_nb > 0) cap_len[cap_nb-1]++;
                end
                cap_high++;
                zrun = 0;
            end else begin
                zrun++;
            end
            prev = IR_LED;
            cap_cycles++;
            @(negedge CLK);
            guard++;
        end
        if (zrun != 10) cap_badgap++;
    endtask

    // code holds six 4-bit burst lengths, START first.
    task automatic check_packet(input string tag, input logic [23:0] code,
                                input int cycles, input int high);
        check({tag, "_nbursts"}, cap_nb, 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_burst%0d", tag, i), cap_len[i], {28'd0, code[23-4*i -: 4]});
        check({tag, "_busy_cycles"}, cap_cycles, cycles);
        check({tag, "_high_cycles"}, cap_high, high);
        check({tag, "_gaps"}, cap_badgap, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         busy_seen;

        RESET_N  = 1'b0;
        BUS_ADDR = 8'h00;
        BUS_WE   = 1'b0;
        tb_en    = 1'b0;
        tb_drv   = 8'h00;

        // Power-on reset state
        repeat (2) @(negedge CLK);
        check("rst_led", {31'd0, IR_LED}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check_released("rst_bus_z");
        RESET_N = 1'b1;
        @(negedge CLK);
        read_reg(STAT_A, d);
        check("rst_status", {24'd0, d}, 32'h00);
        read_reg(CMD_A, d);
        check("rst_cmd", {24'd0, d}, 32'h00);
        check_released("rst_bus_release");

        // Single packet 0x0A: bursts 4,2,3,1,3,1
        write_reg(CMD_A, 8'h0A);
        capture_packet();
        check_packet("pkt0A", 24'h423131, 104, 28);
        check("pkt0A_busy_low", {31'd0, BUSY}, 32'd0);

        // Read CMD: valid one clock after the address, released the next
        read_reg(CMD_A, d);
        check("rd_cmd_0A", {24'd0, d}, 32'h0A);
        check_released("rd_cmd_release");

        // Write landing on the packet-start cycle: old CMD sent, new one queued
        write_reg(CMD_A, 8'h0C);
        write_reg(CMD_A, 8'h03);
        capture_packet();
        check_packet("pkt0C", 24'h423311, 104, 28);
        capture_packet();
        check_packet("pkt03", 24'h421133, 104, 28);

        // Writes during BUSY: last write wins, one packet queued
        write_reg(CMD_A, 8'h06);
        repeat (3) @(negedge CLK);
        write_reg(CMD_A, 8'h05);
        write_reg(CMD_A, 8'h0F);
        read_reg(STAT_A, d);
        check("status_busy_pending", {24'd0, d}, 32'h03);
        read_reg(CMD_A, d);
        check("cmd_last_write", {24'd0, d}, 32'h0F);
        wait_idle("wait_pkt06_end");
        capture_packet();
        check_packet("pkt0F", 24'h423333, 120, 36);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_seen++;
        end
        check("no_pkt05", busy_seen, 32'd0);
        read_reg(STAT_A, d);
        check("status_idle", {24'd0, d}, 32'h00);
        check_released("status_release");

        // Write to STATUS ignored; read outside the map leaves bus released
        write_reg(STAT_A, 8'hFF);
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_seen++;
        end
        check("stat_write_no_busy", busy_seen, 32'd0);
        read_reg(CMD_A, d);
        check("stat_write_cmd_kept", {24'd0, d}, 32'h0F);
        read_reg(STAT_A, d);
        check("stat_write_status", {24'd0, d}, 32'h00);
        BUS_ADDR = 8'h92;
        BUS_WE   = 1'b0;
        @(negedge CLK);
        check_released("rd_92_z");
        BUS_ADDR = 8'h00;

        // Asynchronous reset in the middle of a burst, with a command queued
        write_reg(CMD_A, 8'h0A);
        write_reg(CMD_A, 8'h0B);
        repeat (4) @(negedge CLK);
        begin
            int guard;
            guard = 0;
            while (IR_LED !== 1'b1 && guard < 50) begin
                @(negedge CLK);
                guard++;
            end
        end
        check("led_high_before_reset", {31'd0, IR_LED}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_led", {31'd0, IR_LED}, 32'd0);
        check("async_rst_busy", {31'd0, BUSY}, 32'd0);
        check_released("async_rst_bus_z");
        @(negedge CLK);
        RESET_N = 1'b1;
        read_reg(STAT_A, d);
        check("post_rst_status", {24'd0, d}, 32'h00);
        read_reg(CMD_A, d);
        check("post_rst_cmd", {24'd0, d}, 32'h00);
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (BUSY !== 1'b0 || IR_LED !== 1'b0) busy_seen++;
        end
        check("queued_discarded", busy_seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
